// File: rtl/cmp_rgb_pkg.sv
// Shared types and the reference comparator function for the RGB comparator self-test engine.
package cmp_rgb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // Expected {r,g,b} for vec = {a1,a0,b1,b0}: r = A>B, g = A==B, b = A<B.
    function automatic logic [2:0] golden_rgb(input logic [3:0] vec);
        logic [1:0] a_val;
        logic [1:0] b_val;
        a_val = vec[3:2];
        b_val = vec[1:0];
        return {(a_val > b_val), (a_val == b_val), (a_val < b_val)};
    endfunction

endpackage

// File: rtl/cmp_rgb_bist_if.sv
// Operand/response bus between the self-test engine and the comparator under test.
interface cmp_rgb_bist_if;
    logic a1;
    logic a0;
    logic b1;
    logic b0;
    logic r;
    logic g;
    logic b;

    modport master (output a1, a0, b1, b0, input r, g, b);
    modport slave  (input a1, a0, b1, b0, output r, g, b);
endinterface

// File: rtl/cmp_rgb_bist.sv
// Sweeps all 16 operand combinations into the comparator, holds each for DWELL cycles,
// samples r,g,b once per vector and accumulates pass/fail, failure count and first failing vector.
module cmp_rgb_bist
    import cmp_rgb_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    cmp_rgb_bist_if.master        cmp,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [4:0]            fail_count,
    output logic [3:0]            first_fail_vec
);

    localparam int              CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    bist_state_t       state_q, state_d;
    logic [3:0]        vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [4:0]        fail_count_q, fail_count_d;
    logic [3:0]        first_fail_q, first_fail_d;
    logic              mismatch;

    assign mismatch = ({cmp.r, cmp.g, cmp.b} != golden_rgb(vec_q));

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    vec_d        = 4'h0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_count_d = 5'd0;
                    first_fail_d = 4'h0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // Single sample per vector, taken on the last dwell cycle.
                    if (mismatch) begin
                        fail_count_d = fail_count_q + 5'd1;
                        if (fail_count_q == 5'd0) begin
                            first_fail_d = vec_q;
                        end
                    end
                    if (vec_q == 4'hF) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_count_d == 5'd0);
                    end else begin
                        vec_d = vec_q + 4'h1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= 4'h0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 5'd0;
            first_fail_q <= 4'h0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign cmp.a1         = vec_q[3];
    assign cmp.a0         = vec_q[2];
    assign cmp.b1         = vec_q[1];
    assign cmp.b0         = vec_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_cmp_rgb_bist.sv
// Bench for cmp_rgb_bist: a faultable comparator model drives r,g,b; a cycle model of the sweep is checked every cycle.
module tb_cmp_rgb_bist;

    localparam int D4 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start4 = 1'b0;
    logic start1 = 1'b0;
    int   fault = 0;   // 0 = good comparator, 1 = r stuck-at-0, 2 = g stuck-at-0

    logic       busy4, done4, pass4;
    logic [4:0] fc4;
    logic [3:0] ffv4;
    logic       busy1, done1, pass1;
    logic [4:0] fc1;
    logic [3:0] ffv1;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    cmp_rgb_bist_if cif4();
    cmp_rgb_bist_if cif1();

    always #5 clk = ~clk;

    cmp_rgb_bist #(.DWELL(D4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .cmp(cif4.master),
        .busy(busy4), .done(done4), .pass(pass4),
        .fail_count(fc4), .first_fail_vec(ffv4)
    );

    cmp_rgb_bist #(.DWELL(D1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cmp(cif1.master),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .first_fail_vec(ffv1)
    );

    // Comparator under test (lab_4 behaviour) with optional stuck-at fault.
    function automatic logic [2:0] dut_cmp(input int a, input int b, input int f);
        logic rr, gg, bb;
        rr = (a > b);
        gg = (a == b);
        bb = (a < b);
        if (f == 1) rr = 1'b0;
        if (f == 2) gg = 1'b0;
        return {rr, gg, bb};
    endfunction

    assign {cif4.r, cif4.g, cif4.b} = dut_cmp(int'({cif4.a1, cif4.a0}), int'({cif4.b1, cif4.b0}), fault);
    assign {cif1.r, cif1.g, cif1.b} = dut_cmp(int'({cif1.a1, cif1.a0}), int'({cif1.b1, cif1.b0}), fault);

    // Whole-sweep outcome from arithmetic: walk all 16 vectors and compare against A>B, A==B, A<B.
    function automatic void exp_sweep(input int f, output int fails, output int first);
        fails = 0;
        first = 0;
        for (int v = 0; v < 16; v++) begin
            int a, b;
            logic [2:0] want;
            a = v / 4;
            b = v % 4;
            want = {(a > b), (a == b), (a < b)};
            if (dut_cmp(a, b, f) != want) begin
                if (fails == 0) first = v;
                fails++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model for the DWELL=4 instance.
    bit m_busy = 0, m_done = 0, m_pass = 0;
    int m_t = 0, m_vec = 0, m_fails = 0, m_first = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_pass = 0;
            m_t = 0; m_vec = 0; m_fails = 0; m_first = 0;
        end else if (m_busy) begin
            if (m_t == 16 * D4) begin
                m_busy = 0;
                m_done = 1;
                exp_sweep(fault, m_fails, m_first);
                m_pass = (m_fails == 0);
            end else begin
                m_t++;
                m_vec = (m_t - 1) / D4;
            end
        end else if (start4) begin
            m_busy = 1; m_done = 0; m_pass = 0;
            m_t = 1; m_vec = 0; m_fails = 0; m_first = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] ops;
            ops = {cif4.a1, cif4.a0, cif4.b1, cif4.b0};
            if (m_busy) begin
                chk("run_busy_done_ops", {busy4, done4, ops}, {1'b1, 1'b0, 4'(m_vec)});
                if (m_t == 1)
                    chk("run_cleared", {pass4, fc4, ffv4}, 10'd0);
            end else if (m_done) begin
                chk("done_state", {busy4, done4, pass4, fc4, ffv4, ops},
                    {1'b0, 1'b1, m_pass, 5'(m_fails), 4'(m_first), 4'hF});
            end else begin
                chk("idle_state", {busy4, done4, pass4, fc4, ffv4, ops}, 17'd0);
            end
        end
    end

    task automatic pulse4();
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
    endtask

    // Called at negedge cycle c of a run; returns the cycle on which done is first seen.
    task automatic wait_done4(input int c0, output int c);
        c = c0;
        while (!done4 && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic report(input string tag, input int c);
        $display("sweep %s: fault=%0d done at start+%0d pass=%0b fail_count=%0d first_fail_vec=%h",
                 tag, fault, c, pass4, fc4, ffv4);
    endtask

    initial begin
        int c, ef, efirst;

        // Pin the arithmetic model to hand-computed results.
        exp_sweep(0, ef, efirst); chk("model_good", {ef, efirst}, {32'd0, 32'd0});
        exp_sweep(1, ef, efirst); chk("model_r_sa0", {ef, efirst}, {32'd6, 32'd4});
        exp_sweep(2, ef, efirst); chk("model_g_sa0", {ef, efirst}, {32'd4, 32'd0});

        #1 rst_n = 1'b0;
        #1;
        chk("reset4", {busy4, done4, pass4, fc4, ffv4}, 13'd0);
        chk("reset1", {busy1, done1, pass1, fc1, ffv1}, 13'd0);
        mon_en = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Good comparator
        fault = 0;
        pulse4(); wait_done4(1, c); report("good", c);
        chk("t1_done_cycle", c, 65);
        chk("t1_result", {pass4, fc4, ffv4}, {1'b1, 5'd0, 4'h0});

        // r stuck-at-0
        fault = 1;
        pulse4(); wait_done4(1, c); report("r_sa0", c);
        chk("t2_result", {pass4, fc4, ffv4}, {1'b0, 5'd6, 4'b0100});

        // g stuck-at-0, then restart from DONE
        fault = 2;
        pulse4(); wait_done4(1, c); report("g_sa0", c);
        chk("t3_result", {pass4, fc4, ffv4}, {1'b0, 5'd4, 4'b0000});
        pulse4();
        chk("t3_restart_clear", {busy4, done4, pass4, fc4, ffv4}, {1'b1, 1'b0, 1'b0, 5'd0, 4'h0});
        wait_done4(1, c); report("g_sa0_again", c);
        chk("t3_again_cycle", c, 65);
        chk("t3_again_result", {pass4, fc4, ffv4}, {1'b0, 5'd4, 4'b0000});

        // start re-pulsed mid-run is ignored
        fault = 1;
        pulse4();
        repeat (9) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        wait_done4(11, c); report("restart_ignored", c);
        chk("t4_done_cycle", c, 65);
        chk("t4_result", {pass4, fc4, ffv4}, {1'b0, 5'd6, 4'b0100});

        // Asynchronous reset mid-run
        fault = 0;
        pulse4();
        repeat (29) @(negedge clk);
        chk("t5_busy_before_reset", busy4, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_reset", {busy4, done4, pass4, fc4, ffv4, cif4.a1, cif4.a0, cif4.b1, cif4.b0}, 17'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        pulse4(); wait_done4(1, c); report("after_reset", c);
        chk("t5_done_cycle", c, 65);
        chk("t5_result", {pass4, fc4, ffv4}, {1'b1, 5'd0, 4'h0});

        // DWELL=1 instance: one vector per cycle
        fault = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("t6_ops", {busy1, done1, cif1.a1, cif1.a0, cif1.b1, cif1.b0}, {1'b1, 1'b0, 4'(k)});
            @(negedge clk);
        end
        chk("t6_done17", {busy1, done1, pass1, fc1, ffv1}, {1'b0, 1'b1, 1'b1, 5'd0, 4'h0});
        $display("sweep dwell1: done at start+17 check, pass=%0b fail_count=%0d", pass1, fc1);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
